reg_file_mp: RTL and testbench

Parametrised multi-port register file for the pipelined datapath. It generalises the 2-read/1-write file to NUM_RD read ports and NUM_WR write ports. Reads are registered, with write-to-read bypass, per-port read enables and optional hardwired-zero R0. The decode stage instantiates it, with a second write port for the load/late-writeback path.

---
 rtl/reg_file_mp_pkg.sv | 14 +
 rtl/rf_defs.vh | 12 +
 rtl/rf_read_port.sv | 50 +++++
 rtl/reg_file_mp.sv | 88 ++++++++
 tb/tb_reg_file_mp.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Package for the multi-port register file: supported port-count limits and
// a small helper shared by the read ports.
package reg_file_mp_pkg;

    localparam int RF_MAX_RD = 4;
    localparam int RF_MAX_WR = 2;

    // True when a read must be forced to zero (hardwired R0 enabled and the
    // address is register 0). Bypass data never overrides this.
    function automatic logic r0_forced(input logic r0_zero_en, input logic addr_is_zero);
        return r0_zero_en && addr_is_zero;
    endfunction

endpackage

// File: rtl/rf_defs.vh
// Shared defaults and lane-slice helpers for the multi-port register file.
//   RF_DATA_W / RF_ADDR_W : default register width and address width
//   RF_SLICE(bus, idx, w) : lane idx of a flat bus made of w-bit lanes
`ifndef RF_DEFS_VH
`define RF_DEFS_VH

`define RF_DATA_W 32
`define RF_ADDR_W 5

`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

`endif

// File: rtl/rf_read_port.sv
// One registered read port of the multi-port register file.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears rd)
//   re, ra       : read enable and read address
//   we, wa, wd   : all write ports (flat buses), used for same-edge bypass
//   mem_data     : current array contents at ra (pre-write)
//   rd           : registered read data, held while re=0
`include "rf_defs.vh"

module rf_read_port
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W  = `RF_DATA_W,
    parameter int ADDR_W  = `RF_ADDR_W,
    parameter int NUM_WR  = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          ra,
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   wa,
    input  logic [NUM_WR*DATA_W-1:0]   wd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic [DATA_W-1:0]          rd
);

    logic [DATA_W-1:0] rd_next;

    // Walk write ports lowest to highest so the highest-index hit wins,
    // matching the priority the array itself applies.
    always_comb begin
        rd_next = mem_data;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] && (`RF_SLICE(wa, k, ADDR_W) == ra))
                rd_next = `RF_SLICE(wd, k, DATA_W);
        end
        if (r0_forced(R0_ZERO != 0, ra == '0))
            rd_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd <= '0;
        else if (re)
            rd <= rd_next;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with registered reads and
// write-through bypass.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   we, wa, wd  : NUM_WR write ports (flat buses, port k at lane k)
//   re, ra      : NUM_RD read enables / addresses
//   rd          : NUM_RD registered read-data lanes
//   wr_conflict : registered, high for one cycle after two enabled write
//                 ports targeted the same address
`include "rf_defs.vh"

module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = `RF_DATA_W,
    parameter int ADDR_W   = `RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int R0_ZERO  = 1,
    parameter int INIT_IDX = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   wa,
    input  logic [NUM_WR*DATA_W-1:0]   wd,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic                       wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] mem_rdata;
    logic                     conflict_next;

    // Any pair of enabled write ports on the same address. Writes to R0 are
    // still counted even though they are dropped.
    always_comb begin
        conflict_next = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (we[a] && we[b] && (`RF_SLICE(wa, a, ADDR_W) == `RF_SLICE(wa, b, ADDR_W)))
                    conflict_next = 1'b1;
            end
        end
    end

    // Later loop iterations override earlier ones, giving the
    // highest-index write port priority on a shared address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && !r0_forced(R0_ZERO != 0, `RF_SLICE(wa, k, ADDR_W) == '0))
                    mem[`RF_SLICE(wa, k, ADDR_W)] <= `RF_SLICE(wd, k, DATA_W);
            end
            wr_conflict <= conflict_next;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        assign `RF_SLICE(mem_rdata, j, DATA_W) = mem[`RF_SLICE(ra, j, ADDR_W)];

        rf_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .R0_ZERO (R0_ZERO)
        ) u_rd (
            .clk      (clk),
            .reset    (reset),
            .re       (re[j]),
            .ra       (`RF_SLICE(ra, j, ADDR_W)),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .mem_data (`RF_SLICE(mem_rdata, j, DATA_W)),
            .rd       (`RF_SLICE(rd, j, DATA_W))
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters: 32-bit data,
// 32 entries, 2 read ports, 2 write ports, hardwired R0, index init).
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  wa;
    logic [NW*DW-1:0]  wd;
    logic [NR-1:0]     re;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic              wr_conflict;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: architectural register contents and expected outputs.
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] rd_m  [NR];
    logic          conf_m;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .re          (re),
        .ra          (ra),
        .rd          (rd),
        .wr_conflict (wr_conflict)
    );

    task automatic set_wr(input int k, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[k] = en;
        wa[k*AW +: AW] = a;
        wd[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int j, input logic en, input logic [AW-1:0] a);
        re[j] = en;
        ra[j*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd_lane(input int j);
        return rd[j*DW +: DW];
    endfunction

    // One clock edge: advance the model from the rules (reset wins, writes
    // land with highest port last, reads see the post-write state, R0 reads
    // zero), then step past the edge before anything is sampled.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = DW'(i);
            for (int j = 0; j < NR; j++) rd_m[j] = '0;
            conf_m = 1'b0;
        end else begin
            conf_m = 1'b0;
            for (int a = 0; a < NW; a++)
                for (int b = a + 1; b < NW; b++)
                    if (we[a] && we[b] && wa[a*AW +: AW] == wa[b*AW +: AW]) conf_m = 1'b1;
            for (int k = 0; k < NW; k++)
                if (we[k] && wa[k*AW +: AW] != 0) mem_m[wa[k*AW +: AW]] = wd[k*DW +: DW];
            for (int j = 0; j < NR; j++)
                if (re[j]) rd_m[j] = (ra[j*AW +: AW] == 0) ? '0 : mem_m[ra[j*AW +: AW]];
        end
        #1;
    endtask

    task automatic idle_inputs();
        we = '0; wa = '0; wd = '0; re = '0; ra = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        set_rd(0, 1'b1, 5'd6);
        set_rd(1, 1'b1, 5'd8);
        tick();
        for (int j = 0; j < NR; j++) begin
            total_cnt++;
            if (rd_lane(j) !== '0) $display("FAIL reset_rd%0d: got %h want 0", j, rd_lane(j));
            else pass_cnt++;
        end
        total_cnt++;
        if (wr_conflict !== 1'b0) $display("FAIL reset_conflict: got %b want 0", wr_conflict);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (rd_lane(0) !== 32'd6) $display("FAIL init_rd0: got %0d want 6", rd_lane(0));
        else pass_cnt++;
        total_cnt++;
        if (rd_lane(1) !== 32'd8) $display("FAIL init_rd1: got %0d want 8", rd_lane(1));
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        idle_inputs();
        set_wr(0, 1'b1, 5'd4, 32'd31);
        tick();
        idle_inputs();
        set_rd(0, 1'b1, 5'd4);
        tick();
        total_cnt++;
        if (rd_lane(0) !== 32'd31) $display("FAIL write_read: got %0d want 31", rd_lane(0));
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        set_wr(0, 1'b1, 5'd12, 32'hDEAD);
        set_rd(1, 1'b1, 5'd12);
        tick();
        total_cnt++;
        if (rd_lane(1) !== 32'hDEAD) $display("FAIL bypass_rd1: got %h want dead", rd_lane(1));
        else pass_cnt++;
        total_cnt++;
        if (rd_lane(0) !== 32'd31) $display("FAIL bypass_hold_rd0: got %0d want 31", rd_lane(0));
        else pass_cnt++;
        // Both ports hitting the same bypass address: port 1 must win.
        idle_inputs();
        set_wr(0, 1'b1, 5'd13, 32'h1111);
        set_wr(1, 1'b1, 5'd13, 32'h2222);
        set_rd(0, 1'b1, 5'd13);
        tick();
        total_cnt++;
        if (rd_lane(0) !== 32'h2222) $display("FAIL bypass_priority: got %h want 2222", rd_lane(0));
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        idle_inputs();
        set_wr(0, 1'b1, 5'd9, 32'd5);
        set_wr(1, 1'b1, 5'd9, 32'd7);
        tick();
        total_cnt++;
        if (wr_conflict !== 1'b1) $display("FAIL conflict_set: got %b want 1", wr_conflict);
        else pass_cnt++;
        idle_inputs();
        set_rd(0, 1'b1, 5'd9);
        tick();
        total_cnt++;
        if (wr_conflict !== 1'b0) $display("FAIL conflict_clear: got %b want 0", wr_conflict);
        else pass_cnt++;
        total_cnt++;
        if (rd_lane(0) !== 32'd7) $display("FAIL conflict_winner: got %0d want 7", rd_lane(0));
        else pass_cnt++;
        // Both ports on R0: dropped writes still flag a conflict.
        idle_inputs();
        set_wr(0, 1'b1, 5'd0, 32'd1);
        set_wr(1, 1'b1, 5'd0, 32'd2);
        tick();
        total_cnt++;
        if (wr_conflict !== 1'b1) $display("FAIL conflict_r0: got %b want 1", wr_conflict);
        else pass_cnt++;
    endtask

    task automatic test_r0_hold();
        idle_inputs();
        set_wr(0, 1'b1, 5'd0, 32'h55);
        set_rd(0, 1'b1, 5'd0);
        tick();
        total_cnt++;
        if (rd_lane(0) !== '0) $display("FAIL r0_bypass: got %h want 0", rd_lane(0));
        else pass_cnt++;
        idle_inputs();
        set_rd(0, 1'b0, 5'd4);
        tick();
        total_cnt++;
        if (rd_lane(0) !== '0) $display("FAIL r0_hold: got %h want 0", rd_lane(0));
        else pass_cnt++;
        idle_inputs();
        set_rd(0, 1'b1, 5'd4);
        tick();
        idle_inputs();
        set_rd(0, 1'b0, 5'd5);
        set_wr(1, 1'b1, 5'd5, 32'h77);
        tick();
        total_cnt++;
        if (rd_lane(0) !== 32'd31) $display("FAIL hold_nonzero: got %0d want 31", rd_lane(0));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        reset = 1'b1;
        set_wr(0, 1'b1, 5'd4, 32'h99);
        set_rd(0, 1'b1, 5'd4);
        set_rd(1, 1'b1, 5'd5);
        tick();
        for (int j = 0; j < NR; j++) begin
            total_cnt++;
            if (rd_lane(j) !== '0) $display("FAIL reset_mid_rd%0d: got %h want 0", j, rd_lane(j));
            else pass_cnt++;
        end
        reset = 1'b0;
        idle_inputs();
        set_rd(0, 1'b1, 5'd4);
        tick();
        total_cnt++;
        if (rd_lane(0) !== 32'd4) $display("FAIL reset_mid_reinit: got %0d want 4", rd_lane(0));
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < NW; k++)
                set_wr(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            for (int j = 0; j < NR; j++)
                set_rd(j, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)));
            tick();
            for (int j = 0; j < NR; j++) begin
                total_cnt++;
                if (rd_lane(j) !== rd_m[j])
                    $display("FAIL rand_rd%0d iter %0d: got %h want %h", j, n, rd_lane(j), rd_m[j]);
                else pass_cnt++;
            end
            total_cnt++;
            if (wr_conflict !== conf_m)
                $display("FAIL rand_conflict iter %0d: got %b want %b", n, wr_conflict, conf_m);
            else pass_cnt++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_conflict();
        test_r0_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
